// File: rtl/key_controller.sv
// Memory-mapped pushbutton input device: synchronizes and debounces four
// active-low keys and exposes key state plus a sticky status register on dbus.
module key_controller #(
  parameter int                 DBITS           = 32,
  parameter logic [DBITS-1:0]   DATA_ADDR       = 32'hF000_0010,
  parameter logic [DBITS-1:0]   CTRL_ADDR       = 32'hF000_0110,
  parameter int                 DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [DBITS-1:0] dbus,
  input  logic [DBITS-1:0] address,
  input  logic             wrtEn,
  input  logic [3:0]       KEY,
  output logic             intr
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             ie_q, ie_d;
  logic             rd_data, rd_ctrl, wr_ctrl, change;
  logic [DBITS-1:0] rd_val;

  assign rd_data = (address == DATA_ADDR) && !wrtEn;
  assign rd_ctrl = (address == CTRL_ADDR) && !wrtEn;
  assign wr_ctrl = (address == CTRL_ADDR) && wrtEn;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb infers a latch).
    sync1_d   = ~KEY;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    change    = 1'b0;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    ie_d      = ie_q;

    // One shared counter: any return to the accepted state restarts the window.
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = sync2_q;
      cnt_d   = '0;
      change  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (wr_ctrl) begin
      ie_d = dbus[8];
      if (!dbus[2]) overrun_d = 1'b0;
    end

    // A change arriving while the previous one is unread is an overrun,
    // unless that read completes on this same edge.
    if (change) begin
      ready_d = 1'b1;
      if (ready_q && !rd_data) overrun_d = 1'b1;
    end else if (rd_data) begin
      ready_d = 1'b0;
    end else if (wr_ctrl && !dbus[0]) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before this edge regardless of statement order.
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      ie_q      <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      ie_q      <= ie_d;
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_data) begin
      rd_val[3:0] = state_q;
    end else begin
      rd_val[0] = ready_q;
      rd_val[2] = overrun_q;
      rd_val[8] = ie_q;
    end
  end

  assign dbus = (rd_data || rd_ctrl) ? rd_val : {DBITS{1'bz}};
  assign intr = ready_q & ie_q;

endmodule
